// File: rtl/tilemap_read_arbiter.sv
// Two-port read arbiter for the tilemap memory with locked bursts and ID return pipe.
// Define TILEMAP_ARB_FIXED_PRIO_EN to make port 0 win idle ties instead of round-robin.
module tilemap_read_arbiter #(
  parameter int ADDR_W          = 15,
  parameter int DATA_W          = 4,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_LOCK_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int CNT_W = (MAX_LOCK_CYCLES > 1) ? $clog2(MAX_LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK_CYCLES - 1);
  localparam int PD = MEM_LATENCY + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e           state_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PD-1:0]    pv_q;
  logic [PD-1:0]    pid_q;
  logic             xfer0;
  logic             xfer1;
  logic             xfer;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
`ifdef TILEMAP_ARB_FIXED_PRIO_EN
          gnt0 = req0;
          gnt1 = req1 & ~req0;
`else
          gnt0 = req0 & (~req1 | last_q);
          gnt1 = req1 & (~req0 | ~last_q);
`endif
        end
        OWN0: gnt0 = req0;
        OWN1: gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign xfer0 = req0 & gnt0;
  assign xfer1 = req1 & gnt1;
  assign xfer  = xfer0 | xfer1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      pv_q        <= '0;
      pid_q       <= '0;
      mem_address <= '0;
      rdata       <= '0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
    end else begin
      // oldest pipe slot lines up with mem_data for that read
      pv_q    <= {pv_q[PD-2:0], xfer};
      pid_q   <= {pid_q[PD-2:0], xfer1};
      rvalid0 <= pv_q[PD-1] & ~pid_q[PD-1];
      rvalid1 <= pv_q[PD-1] & pid_q[PD-1];
      if (pv_q[PD-1]) rdata <= mem_data;
      if (xfer) begin
        mem_address <= xfer1 ? addr1 : addr0;
        last_q      <= xfer1;
      end
      unique case (state_q)
        IDLE: begin
          if (xfer0 && lock0) begin
            state_q <= OWN0;
            cnt_q   <= '0;
          end else if (xfer1 && lock1) begin
            state_q <= OWN1;
            cnt_q   <= '0;
          end
        end
        OWN0: begin
          if (!lock0 || cnt_q == CNT_MAX) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        OWN1: begin
          if (!lock1 || cnt_q == CNT_MAX) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tilemap_read_arbiter.sv
// Scoreboard bench for tilemap_read_arbiter: random and directed traffic
// against a transaction-level model of arbitration, locking and read return.
module tb_tilemap_read_arbiter;

  localparam int AW   = 15;
  localparam int DW   = 4;
  localparam int LAT  = 3;
  localparam int MAXL = 16;
`ifdef TILEMAP_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata, mem_data;
  logic [AW-1:0] mem_address;

  always #5 clock = ~clock;

  tilemap_read_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .MAX_LOCK_CYCLES(MAXL)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .lock0(lock0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .lock1(lock1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data)
  );

  logic [DW-1:0] rom [0:(1<<AW)-1];
  logic [DW-1:0] md  [LAT];

  always @(posedge clock) begin
    md[0] <= rom[mem_address];
    for (int i = 1; i < LAT; i++) md[i] <= md[i-1];
  end
  assign mem_data = md[LAT-1];

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int owner = -1;
  int hold = 0;
  int last = 1;
  logic [AW-1:0] exp_ma = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // monitor: every read return must match the oldest outstanding issue
  always @(negedge clock) begin
    if (rvalid0 || rvalid1) begin
      if (rvalid0 && rvalid1) begin
        chk("rvalid_both", 1, 0);
      end else if (sbq.size() == 0) begin
        chk("rvalid_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("rv_port", int'(rvalid1), e.port);
        chk("rdata", int'(rdata), int'(e.data));
        chk("rv_cycle", cyc, e.due);
      end
    end
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      chk("rv_missing", cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
  end

  task automatic step(input bit r0, input bit l0, input logic [AW-1:0] a0,
                      input bit r1, input bit l1, input logic [AW-1:0] a1,
                      output bit g0o, output bit g1o);
    int w;
    int lk;
    @(negedge clock);
    #1;
    chk("mem_address", int'(mem_address), int'(exp_ma));
    req0 = r0; lock0 = l0; addr0 = a0;
    req1 = r1; lock1 = l1; addr1 = a1;
    #1;
    w = -1;
    if (owner < 0) begin
      if (r0 && r1) w = FIXED ? 0 : 1 - last;
      else if (r0) w = 0;
      else if (r1) w = 1;
    end else if (owner == 0 ? r0 : r1) begin
      w = owner;
    end
    chk("gnt0", int'(gnt0), int'(w == 0));
    chk("gnt1", int'(gnt1), int'(w == 1));
    g0o = (w == 0);
    g1o = (w == 1);
    if (w >= 0) begin
      sbq.push_back('{w, rom[w == 1 ? a1 : a0], cyc + LAT + 2});
      exp_ma = (w == 1) ? a1 : a0;
      last = w;
    end
    if (owner < 0) begin
      lk = (w == 1) ? l1 : l0;
      if (w >= 0 && lk != 0) begin
        owner = w;
        hold = 0;
      end
    end else begin
      lk = (owner == 1) ? l1 : l0;
      if (hold == MAXL - 1 || lk == 0) owner = -1;
      else hold++;
    end
  endtask

  task automatic idle(input int n);
    bit g0, g1;
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, g0, g1);
  endtask

  task automatic model_reset();
    owner = -1;
    hold = 0;
    last = 1;
    exp_ma = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit g0, g1, p0, p1, r0, r1, l0, l1, seen0;
    logic [AW-1:0] a0, a1, x;
    int streak, first0;

    for (int i = 0; i < (1 << AW); i++) rom[i] = DW'($urandom);
    rom[15'h07D1] = 4'h3;
    for (int i = 0; i < LAT; i++) md[i] = '0;

    // reset state, with both requests high
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("rst_gnt0", int'(gnt0), 0);
      chk("rst_gnt1", int'(gnt1), 0);
      chk("rst_rvalid", int'(rvalid0 | rvalid1), 0);
      chk("rst_rdata", int'(rdata), 0);
      chk("rst_mem_address", int'(mem_address), 0);
    end
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    model_reset();

    // single read on port 1
    step(0, 0, '0, 1, 0, 15'h07D1, g0, g1);
    chk("single_gnt1", int'(g1), 1);
    idle(LAT + 2);

    // contention, no lock
    for (int i = 0; i < 6; i++)
      step(1, 0, AW'($urandom), 1, 0, AW'($urandom), g0, g1);
    idle(2);

    // locked neighbour burst on port 1 while port 0 waits
    x = 15'h1234;
    step(0, 0, '0, 1, 1, x + 15'd1, g0, g1);
    step(1, 0, 15'h0042, 1, 1, x - 15'd1, g0, g1);
    step(1, 0, 15'h0042, 1, 1, x - 15'd128, g0, g1);
    step(1, 0, 15'h0042, 1, 0, x + 15'd128, g0, g1);
    chk("burst_last_gnt1", int'(g1), 1);
    step(1, 0, 15'h0042, 0, 0, '0, g0, g1);
    chk("burst_release_gnt0", int'(g0), 1);
    idle(LAT + 2);

    // lock timeout
    streak = 0;
    first0 = -1;
    seen0 = 1'b0;
    step(0, 0, '0, 1, 1, AW'($urandom), g0, g1);
    if (g1) streak++;
    for (int i = 1; i < 20; i++) begin
      step(1, 0, AW'($urandom), 1, 1, AW'($urandom), g0, g1);
      if (g0 && !seen0) begin
        seen0 = 1'b1;
        first0 = i;
      end
      if (g1 && !seen0) streak++;
    end
    chk("timeout_streak", streak, MAXL + 1);
    chk("timeout_first_gnt0", first0, MAXL + 1);
    step(0, 0, '0, 1, 0, '0, g0, g1);
    idle(LAT + 2);

    // reset with three reads in flight
    for (int i = 0; i < 3; i++) step(1, 0, AW'($urandom), 0, 0, '0, g0, g1);
    @(negedge clock);
    #1;
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    sbq.delete();
    #1;
    chk("midrst_gnt0", int'(gnt0), 0);
    chk("midrst_gnt1", int'(gnt1), 0);
    @(negedge clock);
    #1;
    chk("midrst_mem_address", int'(mem_address), 0);
    chk("midrst_rvalid", int'(rvalid0 | rvalid1), 0);
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    model_reset();
    idle(LAT + 3);

    // random traffic; requests held until granted
    p0 = 1'b0; p1 = 1'b0;
    a0 = '0; a1 = '0; r0 = 1'b0; r1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      int lp;
      lp = (c < 750) ? 4 : 15;
      if (!p0) begin
        r0 = ($urandom % 4) != 0;
        a0 = AW'($urandom);
      end
      if (!p1) begin
        r1 = ($urandom % 4) != 0;
        a1 = AW'($urandom);
      end
      l0 = ($urandom % 16) < lp;
      l1 = ($urandom % 16) < lp;
      step(r0, l0, a0, r1, l1, a1, g0, g1);
      p0 = r0 && !g0;
      p1 = r1 && !g1;
    end

    idle(LAT + 4);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
